// File: rtl/reset_shutdown_sequencer.sv
// reset_shutdown_sequencer
//   Master-clock controller for the per-domain reset synchronizers. It
//   sequences software reset pulses and the shutdown flow: assert reset,
//   confirm every domain is in reset, then gate the non-master clocks.
//   Wakeup runs the reverse order: ungate, release reset, confirm that every
//   domain is out of reset.
//
//   Optional feature macro: RESET_SEQ_TIMEOUT_EN
//     When defined, the WAIT_ALL and RELEASE waits give up after
//     TIMEOUT_CYCLES cycles. They then set the sticky timeout_err flag and
//     continue as if the awaited condition had been met.
//     When undefined, both waits are unbounded and timeout_err is tied to 0.
//
// Ports
//   clk              master clock, always running
//   rst              synchronous active-high reset
//   req_reset        pulse: reset all domains, then return to RUN
//   req_shutdown     pulse: reset all domains, then gate their clocks
//   req_wakeup       pulse: leave OFF
//   all_reset_in     every domain reports that it is in reset
//   domains_resn_in  per-domain reset status, low = in reset
//   resn_req_out     active-low reset request to the synchronizers
//   clk_en_out       per-domain clock enable; bit 0 (master) is always 1
//   busy             high in every state except RUN and OFF
//   shut_down        high in OFF
//   done             one-cycle pulse in the first RUN cycle after a sequence
//   state_out        current state encoding, for debug
//   timeout_err      sticky timeout flag
module reset_shutdown_sequencer #(
    parameter int CLOCKS         = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int GATE_DELAY     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_reset,
    input  logic              req_shutdown,
    input  logic              req_wakeup,
    input  logic              all_reset_in,
    input  logic [CLOCKS-1:0] domains_resn_in,
    output logic              resn_req_out,
    output logic [CLOCKS-1:0] clk_en_out,
    output logic              busy,
    output logic              shut_down,
    output logic              done,
    output logic [2:0]        state_out,
    output logic              timeout_err
);

    localparam int MAX_HG  = (HOLD_CYCLES > GATE_DELAY) ? HOLD_CYCLES : GATE_DELAY;
    localparam int MAX_CNT = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0]     HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]     GATE_LAST = CW'(GATE_DELAY - 1);
    localparam logic [CW-1:0]     CNT_SAT   = '1;
    localparam logic [CLOCKS-1:0] EN_MASTER = CLOCKS'(1);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_ASSERT  = 3'd1,
        ST_WAIT_ALL = 3'd2,
        ST_GATE    = 3'd3,
        ST_OFF     = 3'd4,
        ST_UNGATE  = 3'd5,
        ST_RELEASE = 3'd6
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          shutdown_flag;
    logic          wait_expired;
    logic          all_out_of_reset;

    assign all_out_of_reset = &domains_resn_in;
    assign state_out        = state;

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    assign wait_expired = (cnt == TO_LAST);
`else
    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    // Outputs are assigned together with the transition into the state that
    // owns them, so every output is a flop that already reflects the current
    // state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            cnt           <= '0;
            shutdown_flag <= 1'b0;
            resn_req_out  <= 1'b1;
            clk_en_out    <= '1;
            busy          <= 1'b0;
            shut_down     <= 1'b0;
            done          <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
            timeout_err   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_RUN: begin
                    // Shutdown wins over a simultaneous reset request.
                    if (req_shutdown || req_reset) begin
                        shutdown_flag <= req_shutdown;
                        state         <= ST_ASSERT;
                        cnt           <= '0;
                        resn_req_out  <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (cnt == HOLD_LAST) begin
                        state <= ST_WAIT_ALL;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_ALL: begin
                    if (all_reset_in || wait_expired) begin
`ifdef RESET_SEQ_TIMEOUT_EN
                        if (!all_reset_in) timeout_err <= 1'b1;
`endif
                        cnt <= '0;
                        if (shutdown_flag) begin
                            state <= ST_GATE;
                        end else begin
                            state        <= ST_RELEASE;
                            resn_req_out <= 1'b1;
                        end
                    end else if (cnt != CNT_SAT) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GATE: begin
                    if (cnt == GATE_LAST) begin
                        state      <= ST_OFF;
                        cnt        <= '0;
                        clk_en_out <= EN_MASTER;
                        busy       <= 1'b0;
                        shut_down  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_OFF: begin
                    if (req_wakeup) begin
                        state      <= ST_UNGATE;
                        cnt        <= '0;
                        clk_en_out <= '1;
                        busy       <= 1'b1;
                        shut_down  <= 1'b0;
                    end
                end
                ST_UNGATE: begin
                    if (cnt == GATE_LAST) begin
                        state        <= ST_RELEASE;
                        cnt          <= '0;
                        resn_req_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (all_out_of_reset || wait_expired) begin
`ifdef RESET_SEQ_TIMEOUT_EN
                        if (!all_out_of_reset) timeout_err <= 1'b1;
`endif
                        state <= ST_RUN;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (cnt != CNT_SAT) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= ST_RUN;
                    cnt          <= '0;
                    resn_req_out <= 1'b1;
                    clk_en_out   <= '1;
                    busy         <= 1'b0;
                    shut_down    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_shutdown_sequencer.sv
// Testbench for reset_shutdown_sequencer.
// Two instances are used: dut_a (CLOCKS=2, HOLD=16, GATE=4, TIMEOUT=32) and
// dut_b (CLOCKS=4, HOLD=1, GATE=1). sel picks which one receives requests
// and which one the responder and monitor observe.
module tb_reset_shutdown_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sel;
    logic       req_reset, req_shutdown, req_wakeup;
    logic       all_reset_in;
    logic [3:0] domains;

    logic       a_resn, a_busy, a_shut, a_done, a_te;
    logic [1:0] a_clk_en;
    logic [2:0] a_state;
    logic       b_resn, b_busy, b_shut, b_done, b_te;
    logic [3:0] b_clk_en;
    logic [2:0] b_state;

    reset_shutdown_sequencer #(
        .CLOCKS(2), .HOLD_CYCLES(16), .GATE_DELAY(4), .TIMEOUT_CYCLES(32)
    ) dut_a (
        .clk(clk), .rst(rst),
        .req_reset(req_reset & ~sel), .req_shutdown(req_shutdown & ~sel),
        .req_wakeup(req_wakeup & ~sel), .all_reset_in(all_reset_in),
        .domains_resn_in(domains[1:0]), .resn_req_out(a_resn),
        .clk_en_out(a_clk_en), .busy(a_busy), .shut_down(a_shut),
        .done(a_done), .state_out(a_state), .timeout_err(a_te)
    );

    reset_shutdown_sequencer #(
        .CLOCKS(4), .HOLD_CYCLES(1), .GATE_DELAY(1), .TIMEOUT_CYCLES(1024)
    ) dut_b (
        .clk(clk), .rst(rst),
        .req_reset(req_reset & sel), .req_shutdown(req_shutdown & sel),
        .req_wakeup(req_wakeup & sel), .all_reset_in(all_reset_in),
        .domains_resn_in(domains), .resn_req_out(b_resn),
        .clk_en_out(b_clk_en), .busy(b_busy), .shut_down(b_shut),
        .done(b_done), .state_out(b_state), .timeout_err(b_te)
    );

    // Observed view of the selected instance.
    logic       m_resn, m_busy, m_shut, m_done, m_te;
    logic [3:0] m_clk_en, full_mask;
    logic [2:0] m_state;
    assign m_resn    = sel ? b_resn  : a_resn;
    assign m_busy    = sel ? b_busy  : a_busy;
    assign m_shut    = sel ? b_shut  : a_shut;
    assign m_done    = sel ? b_done  : a_done;
    assign m_te      = sel ? b_te    : a_te;
    assign m_state   = sel ? b_state : a_state;
    assign m_clk_en  = sel ? b_clk_en : {2'b00, a_clk_en};
    assign full_mask = sel ? 4'hF : 4'h3;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard: kind 0 = done pulse, kind 1 = entry into OFF.
    // Fields set to -1 are not compared.
    typedef struct {
        int kind;
        int low;
        int gate;
        int ungate;
        int rel;
        int clk;
        int te;
    } exp_t;
    exp_t sb[$];

    task automatic expect_ev(input int kind, input int low, input int gate,
                             input int ungate, input int rel, input int clk_v,
                             input int te);
        exp_t e;
        e.kind = kind; e.low = low; e.gate = gate; e.ungate = ungate;
        e.rel = rel; e.clk = clk_v; e.te = te;
        sb.push_back(e);
    endtask

    // Domain responder: all_reset_in rises on the ar_delay-th WAIT_ALL
    // cycle; domains come out of reset dr_delay cycles after resn rises,
    // optionally passing through a partial 4'h7 from dr_part cycles on.
    int ar_delay = 3;
    int dr_delay = 5;
    int dr_part  = 0;
    int wcnt     = 0;
    int rcnt     = 1000;

    initial begin
        all_reset_in = 1'b0;
        domains      = 4'hF;
    end

    always @(negedge clk) begin
        if (m_state == 3'd2) begin
            wcnt++;
            all_reset_in = (wcnt >= ar_delay);
        end else if (m_resn) begin
            wcnt = 0;
            all_reset_in = 1'b0;
        end
        if (!m_resn) begin
            rcnt = 0;
            domains = 4'h0;
        end else begin
            if (rcnt < 100000) rcnt++;
            if (rcnt >= dr_delay)                    domains = 4'hF;
            else if (dr_part > 0 && rcnt >= dr_part) domains = 4'h7;
            else                                     domains = 4'h0;
        end
    end

    // Monitor: measures each sequence and compares it at the done pulse or
    // at entry into OFF against the next scoreboard entry.
    int low_cnt, gate_cnt, ungate_cnt, rel_cnt, busy_bad;
    logic [3:0] clk_and;
    logic prev_resn, prev_shut;

    task automatic clear_trackers();
        gate_cnt = 0; ungate_cnt = 0; rel_cnt = 0; busy_bad = 0;
        clk_and = full_mask;
    endtask

    initial begin
        low_cnt = 0; prev_resn = 1'b1; prev_shut = 1'b0;
        clear_trackers();
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            low_cnt = 0; prev_resn = 1'b1; prev_shut = 1'b0;
            clear_trackers();
        end else begin
            if (!m_resn) begin
                if (prev_resn) begin
                    low_cnt = 0;
                    clear_trackers();
                end
                low_cnt++;
            end
            if (m_state == 3'd3) gate_cnt++;
            if (m_state == 3'd5 && m_clk_en == full_mask) ungate_cnt++;
            if (m_state == 3'd6) rel_cnt++;
            if (m_state != 3'd4) clk_and = clk_and & m_clk_en;
            if (m_busy != !(m_state == 3'd0 || m_state == 3'd4)) busy_bad++;

            if (m_done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    check("event_kind_done", 0, e.kind);
                    check("done_state", int'(m_state), 0);
                    check("done_resn", int'(m_resn), 1);
                    if (e.low >= 0) check("resn_low_cycles", low_cnt, e.low);
                    check("ungate_cycles", ungate_cnt, e.ungate);
                    check("release_cycles", rel_cnt, e.rel);
                    check("clk_en_during_seq", int'(clk_and), e.clk);
                    check("timeout_err_at_done", int'(m_te), e.te);
                    check("busy_profile", busy_bad, 0);
                end
            end

            if (m_shut && !prev_shut) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_off actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    check("event_kind_off", 1, e.kind);
                    check("off_state", int'(m_state), 4);
                    check("off_resn", int'(m_resn), 0);
                    if (e.low >= 0) check("resn_low_to_off", low_cnt, e.low);
                    check("gate_cycles", gate_cnt, e.gate);
                    check("off_clk_en", int'(m_clk_en), e.clk);
                    check("busy_profile_off", busy_bad, 0);
                end
                clear_trackers();
            end
            prev_resn = m_resn;
            prev_shut = m_shut;
        end
    end

    task automatic pulse(input logic r, input logic s, input logic w);
        @(negedge clk); #1;
        req_reset = r; req_shutdown = s; req_wakeup = w;
        @(negedge clk); #1;
        req_reset = 1'b0; req_shutdown = 1'b0; req_wakeup = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0;
        req_reset = 1'b0; req_shutdown = 1'b0; req_wakeup = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", int'(a_state), 0);
        check("rst_resn", int'(a_resn), 1);
        check("rst_clk_en", int'(a_clk_en), 3);
        check("rst_clk_en_b", int'(b_clk_en), 15);
        check("rst_busy", int'(a_busy), 0);
        check("rst_shut", int'(a_shut), 0);
        check("rst_done", int'(a_done), 0);
        check("rst_te", int'(a_te), 0);
        #1 rst = 1'b0;

        // Reset pulse: 16 ASSERT + 3 WAIT_ALL cycles low, 5 RELEASE cycles.
        ar_delay = 3; dr_delay = 5;
        expect_ev(0, 19, 0, 0, 5, 3, 0);
        pulse(1'b1, 1'b0, 1'b0);
        drain("reset_pulse", 200);

        // Shutdown: 16 + 2 + 4 GATE + first OFF cycle = 23 low samples.
        ar_delay = 2;
        expect_ev(1, 23, 4, 0, 0, 1, 0);
        pulse(1'b0, 1'b1, 1'b0);
        drain("shutdown", 200);
        check("off_shut_down", int'(m_shut), 1);
        check("off_busy", int'(m_busy), 0);
        expect_ev(0, -1, 0, 4, 5, 3, 0);
        pulse(1'b0, 1'b0, 1'b1);
        check("wake_first_state", int'(m_state), 5);
        check("wake_first_clk_en", int'(m_clk_en), 3);
        check("wake_first_resn", int'(m_resn), 0);
        drain("wakeup", 200);

        // Simultaneous reset+shutdown takes the shutdown path.
        expect_ev(1, 23, 4, 0, 0, 1, 0);
        pulse(1'b1, 1'b1, 1'b0);
        drain("simultaneous", 200);
        expect_ev(0, -1, 0, 4, 5, 3, 0);
        pulse(1'b0, 1'b0, 1'b1);
        drain("simultaneous_wake", 200);

        // A second req_reset during ASSERT is dropped: same timing, one done.
        ar_delay = 3;
        expect_ev(0, 19, 0, 0, 5, 3, 0);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        drain("dropped_req", 200);
        repeat (30) @(negedge clk);

        // req_wakeup in RUN has no effect.
        pulse(1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("wake_in_run_state", int'(m_state), 0);
        check("wake_in_run_busy", int'(m_busy), 0);
        check("wake_in_run_resn", int'(m_resn), 1);

        // rst while OFF aborts straight to RUN defaults, no done.
        ar_delay = 2;
        expect_ev(1, 23, 4, 0, 0, 1, 0);
        pulse(1'b0, 1'b1, 1'b0);
        drain("shutdown_before_rst", 200);
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("abort_state", int'(m_state), 0);
        check("abort_resn", int'(m_resn), 1);
        check("abort_clk_en", int'(m_clk_en), 3);
        check("abort_shut", int'(m_shut), 0);
        check("abort_done", int'(m_done), 0);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);

`ifdef RESET_SEQ_TIMEOUT_EN
        // WAIT_ALL gives up after 32 cycles: 16 + 32 = 48 low samples.
        ar_delay = 1000000;
        expect_ev(0, 48, 0, 0, 5, 3, 1);
        pulse(1'b1, 1'b0, 1'b0);
        drain("timeout", 300);
        ar_delay = 3;
        expect_ev(0, 19, 0, 0, 5, 3, 1);
        pulse(1'b1, 1'b0, 1'b0);
        drain("after_timeout", 200);
        check("timeout_sticky", int'(m_te), 1);
        rst_pulse();
        check("timeout_cleared", int'(m_te), 0);
`else
        // Without the timeout the FSM waits in WAIT_ALL indefinitely.
        ar_delay = 1000000;
        pulse(1'b1, 1'b0, 1'b0);
        repeat (1100) @(negedge clk);
        check("no_timeout_state", int'(m_state), 2);
        check("no_timeout_err", int'(m_te), 0);
        check("no_timeout_resn", int'(m_resn), 0);
        rst_pulse();
        check("no_timeout_recover", int'(m_state), 0);
`endif

        // CLOCKS=4, HOLD=1, GATE=1 instance: 1 + 2 + 1 + 1 = 5 low samples.
        @(negedge clk); #1 sel = 1'b1;
        ar_delay = 2; dr_delay = 10; dr_part = 4;
        repeat (2) @(negedge clk);
        expect_ev(1, 5, 1, 0, 0, 1, 0);
        pulse(1'b0, 1'b1, 1'b0);
        drain("b_shutdown", 100);
        expect_ev(0, -1, 0, 1, 10, 15, 0);
        pulse(1'b0, 1'b0, 1'b1);
        drain("b_wakeup", 100);

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
